// File: rtl/csr_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode CSR file and trap controller:
// CSR addresses, op codes, status bit positions, privilege codes and helpers.
package csr_trap_ctrl_pkg;

  localparam int CSR_OP_WIDTH = 3;
  localparam logic [2:0] CSR_OP_RW  = 3'b001;
  localparam logic [2:0] CSR_OP_RS  = 3'b010;
  localparam logic [2:0] CSR_OP_RC  = 3'b011;
  localparam logic [2:0] CSR_OP_RWI = 3'b101;
  localparam logic [2:0] CSR_OP_RSI = 3'b110;
  localparam logic [2:0] CSR_OP_RCI = 3'b111;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MARCHID  = 12'hF12;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPRV = 17;
  localparam logic [31:0] MSTATUS_WMASK = 32'h0002_1888;
  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

  localparam int MIP_MSIP  = 3;
  localparam int MIP_MTIP  = 7;
  localparam int MIP_MEIP  = 11;
  localparam int LIRQ_BASE = 16;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [4:0] IRQ_ID_MSI = 5'd3;
  localparam logic [4:0] IRQ_ID_MTI = 5'd7;
  localparam logic [4:0] IRQ_ID_MEI = 5'd11;

  localparam logic [31:0] MISA_VAL    = 32'h4010_1101;
  localparam logic [31:0] MARCHID_VAL = 32'h0000_002b;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_TRAP} irq_state_t;

  function automatic logic [31:0] mie_mask(input int n);
    logic [31:0] m;
    m = 32'h0000_0888;
    for (int i = 0; i < n; i++) m[LIRQ_BASE+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] trap_mstatus(input logic [31:0] s, input logic [1:0] priv);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[12:11]        = priv;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[12:11]        = PRIV_U;
    if (s[12:11] != PRIV_M) r[MSTATUS_MPRV] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl_irq_arbiter.sv
// Interrupt input synchronisers (mip bit layout) and fixed-priority encoder
// over the pending-and-enabled word: MEI > MSI > MTI > local lines (lowest first).
module irq_arbiter
  import csr_trap_ctrl_pkg::*;
#(
  parameter int NUM_LIRQ    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 irq_msip,
  input  logic                                 irq_mtip,
  input  logic                                 irq_meip,
  input  logic [(NUM_LIRQ>0?NUM_LIRQ:1)-1:0]   irq_local,
  input  logic [31:0]                          active,
  output logic [31:0]                          sync_lines,
  output logic                                 any_irq,
  output logic [4:0]                           irq_id
);

  logic [31:0] raw;
  logic        unused_lirq;

  // With no local lines the single spare port bit is never sampled.
  assign unused_lirq = ^irq_local;

  always_comb begin
    raw = '0;
    raw[MIP_MSIP] = irq_msip;
    raw[MIP_MTIP] = irq_mtip;
    raw[MIP_MEIP] = irq_meip;
    for (int i = 0; i < NUM_LIRQ; i++) raw[LIRQ_BASE+i] = irq_local[i];
  end

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_lines = raw;
    end else begin : g_sync
      logic [31:0] stage_q [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (!resetn) begin
          for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= '0;
        end else begin
          stage_q[0] <= raw;
          for (int s = 1; s < SYNC_STAGES; s++) stage_q[s] <= stage_q[s-1];
        end
      end
      assign sync_lines = stage_q[SYNC_STAGES-1];
    end
  endgenerate

  assign any_irq = |active;

  // Later assignments override earlier ones, so lowest priority goes first.
  always_comb begin
    irq_id = '0;
    for (int i = NUM_LIRQ - 1; i >= 0; i--)
      if (active[LIRQ_BASE+i]) irq_id = 5'(LIRQ_BASE + i);
    if (active[MIP_MTIP]) irq_id = IRQ_ID_MTI;
    if (active[MIP_MSIP]) irq_id = IRQ_ID_MSI;
    if (active[MIP_MEIP]) irq_id = IRQ_ID_MEI;
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file, counters and trap controller with a registered
// interrupt request/ack handshake and vectored dispatch for interrupts.
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC_INIT    = 32'h0000_0000,
  parameter int          NUM_LIRQ      = 0,
  parameter int          SYNC_STAGES   = 2,
  parameter int          COUNTER_WIDTH = 64
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [11:0]                        csr_addr,
  input  logic [CSR_OP_WIDTH-1:0]            csr_op,
  input  logic                               csr_we,
  input  logic                               csr_re,
  input  logic [31:0]                        rs1_data,
  input  logic [4:0]                         uimm,
  output logic [31:0]                        rdata,
  output logic                               access_fault,
  input  logic                               exception_event,
  input  logic [31:0]                        cause,
  input  logic [31:0]                        pc,
  input  logic [31:0]                        badaddr,
  input  logic                               mret,
  input  logic                               wfi,
  input  logic                               inst_retired,
  input  logic                               irq_msip,
  input  logic                               irq_mtip,
  input  logic                               irq_meip,
  input  logic [(NUM_LIRQ>0?NUM_LIRQ:1)-1:0] irq_local,
  output logic                               irq_pending,
  input  logic                               irq_ack,
  output logic                               wfi_wake,
  output logic [31:0]                        trap_pc,
  output logic                               trap_select,
  output logic [1:0]                         privilege_mode,
  output logic [31:0]                        mstatus,
  output logic [31:0]                        mie,
  output logic [31:0]                        mip
);

  localparam logic [31:0] MIE_WMASK = mie_mask(NUM_LIRQ);

  irq_state_t               state;
  logic [4:0]               irq_id, win_id;
  logic                     any_irq, gie, irq_cond, take_irq, csr_commit;
  logic [31:0]              sync_lines, mscratch, mtvec, mepc, mcause, mtval;
  logic [31:0]              csr_val, operand, wval, mstatus_wr, trap_base;
  logic [COUNTER_WIDTH-1:0] cycle_cnt, instret_cnt;
  logic [63:0]              cycle64, instret64;
  logic                     unused_wfi;

  irq_arbiter #(.NUM_LIRQ(NUM_LIRQ), .SYNC_STAGES(SYNC_STAGES)) u_irq_arbiter (
    .clk        (clk),
    .resetn     (resetn),
    .irq_msip   (irq_msip),
    .irq_mtip   (irq_mtip),
    .irq_meip   (irq_meip),
    .irq_local  (irq_local),
    .active     (mip & mie),
    .sync_lines (sync_lines),
    .any_irq    (any_irq),
    .irq_id     (win_id)
  );

  // WFI only stalls the core; the wake condition is reported independently of it.
  assign unused_wfi   = wfi;
  assign wfi_wake     = |(mip & mie);
  assign gie          = (privilege_mode == PRIV_M) ? mstatus[MSTATUS_MIE] : 1'b1;
  assign irq_cond     = any_irq & gie;
  assign take_irq     = (state == ST_REQ) & irq_ack & ~exception_event & ~mret;
  assign access_fault = (privilege_mode < csr_addr[9:8]) | (csr_we & (csr_addr[11:10] == 2'b11));
  assign csr_commit   = csr_we & ~exception_event & ~mret & ~access_fault & ~take_irq;
  assign trap_base    = {mtvec[31:2], 2'b00};
  assign cycle64      = 64'(cycle_cnt);
  assign instret64    = 64'(instret_cnt);
  assign rdata        = csr_re ? csr_val : '0;

  always_comb begin
    csr_val = '0;
    case (csr_addr)
      CSR_MSTATUS:            csr_val = mstatus;
      CSR_MISA:               csr_val = MISA_VAL;
      CSR_MIE:                csr_val = mie;
      CSR_MTVEC:              csr_val = mtvec;
      CSR_MSCRATCH:           csr_val = mscratch;
      CSR_MEPC:               csr_val = mepc;
      CSR_MCAUSE:             csr_val = mcause;
      CSR_MTVAL:              csr_val = mtval;
      CSR_MIP:                csr_val = mip;
      CSR_CYCLE, CSR_TIME:    csr_val = cycle64[31:0];
      CSR_CYCLEH, CSR_TIMEH:  csr_val = cycle64[63:32];
      CSR_INSTRET:            csr_val = instret64[31:0];
      CSR_INSTRETH:           csr_val = instret64[63:32];
      CSR_MARCHID:            csr_val = MARCHID_VAL;
      default:                csr_val = '0;
    endcase
  end

  always_comb begin
    operand = csr_op[2] ? {27'b0, uimm} : rs1_data;
    case (csr_op)
      CSR_OP_RW, CSR_OP_RWI: wval = operand;
      CSR_OP_RS, CSR_OP_RSI: wval = csr_val | operand;
      CSR_OP_RC, CSR_OP_RCI: wval = csr_val & ~operand;
      default:               wval = csr_val;
    endcase
    // MPP only holds M or U; anything else collapses to U.
    mstatus_wr = wval & MSTATUS_WMASK;
    mstatus_wr[12:11] = (wval[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + COUNTER_WIDTH'(1);
      if (inst_retired) instret_cnt <= instret_cnt + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      irq_pending    <= 1'b0;
      irq_id         <= '0;
      trap_select    <= 1'b0;
      trap_pc        <= '0;
      privilege_mode <= PRIV_M;
      mstatus        <= MSTATUS_RESET;
      mie            <= '0;
      mip            <= '0;
      mscratch       <= '0;
      mtvec          <= MTVEC_INIT;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
    end else begin
      mip         <= sync_lines;
      trap_select <= 1'b0;
      if (csr_commit) begin
        case (csr_addr)
          CSR_MSTATUS:  mstatus  <= mstatus_wr;
          CSR_MIE:      mie      <= wval & MIE_WMASK;
          CSR_MTVEC:    mtvec    <= {wval[31:2], 1'b0, wval[0]};
          CSR_MSCRATCH: mscratch <= wval;
          CSR_MEPC:     mepc     <= wval;
          CSR_MCAUSE:   mcause   <= wval;
          CSR_MTVAL:    mtval    <= wval;
          default: ;
        endcase
      end
      if (exception_event) begin
        mstatus        <= trap_mstatus(mstatus, privilege_mode);
        privilege_mode <= PRIV_M;
        mcause         <= cause;
        mepc           <= pc;
        mtval          <= (&badaddr) ? pc : badaddr;
        trap_pc        <= trap_base;
        trap_select    <= 1'b1;
      end else if (mret) begin
        mstatus        <= mret_mstatus(mstatus);
        privilege_mode <= mstatus[12:11];
        trap_pc        <= mepc;
        trap_select    <= 1'b1;
      end else if (take_irq) begin
        mstatus        <= trap_mstatus(mstatus, privilege_mode);
        privilege_mode <= PRIV_M;
        mcause         <= {1'b1, 26'b0, irq_id};
        mepc           <= pc;
        mtval          <= '0;
        trap_pc        <= (mtvec[1:0] == 2'b01) ? trap_base + {25'b0, irq_id, 2'b00} : trap_base;
        trap_select    <= 1'b1;
      end
      case (state)
        ST_IDLE: if (irq_cond) begin
          state       <= ST_REQ;
          irq_pending <= 1'b1;
          irq_id      <= win_id;
        end
        ST_REQ: begin
          // A trap or mret this cycle holds REQ; the request is re-judged next cycle.
          if (take_irq) begin
            state       <= ST_TRAP;
            irq_pending <= 1'b0;
          end else if (!(exception_event | mret)) begin
            if (!irq_cond) begin
              state       <= ST_IDLE;
              irq_pending <= 1'b0;
            end else begin
              irq_id <= win_id;
            end
          end
        end
        ST_TRAP: begin
          state       <= ST_IDLE;
          irq_pending <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          irq_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: CSR reads and trap redirects are queued
// as expectations by the stimulus and checked by a negedge monitor.
module tb_csr_trap_ctrl;

  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RSI = 3'b110;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [2:0]  csr_op = '0;
  logic        csr_we = 1'b0, csr_re = 1'b0;
  logic [31:0] rs1_data = '0;
  logic [4:0]  uimm = '0;
  logic [31:0] rdata;
  logic        access_fault;
  logic        exception_event = 1'b0;
  logic [31:0] cause = '0, pc = '0, badaddr = '0;
  logic        mret = 1'b0, wfi = 1'b0, inst_retired = 1'b0;
  logic        irq_msip = 1'b0, irq_mtip = 1'b0, irq_meip = 1'b0;
  logic [3:0]  irq_local = '0;
  logic        irq_pending, irq_ack = 1'b0, wfi_wake, trap_select;
  logic [31:0] trap_pc, mstatus, mie, mip;
  logic [1:0]  privilege_mode;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [31:0] trap_exp_q[$];

  always #5 clk = ~clk;

  csr_trap_ctrl #(
    .MTVEC_INIT(32'h0000_0200), .NUM_LIRQ(4), .SYNC_STAGES(2), .COUNTER_WIDTH(64)
  ) dut (
    .clk(clk), .resetn(resetn), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_we(csr_we), .csr_re(csr_re), .rs1_data(rs1_data), .uimm(uimm),
    .rdata(rdata), .access_fault(access_fault), .exception_event(exception_event),
    .cause(cause), .pc(pc), .badaddr(badaddr), .mret(mret), .wfi(wfi),
    .inst_retired(inst_retired), .irq_msip(irq_msip), .irq_mtip(irq_mtip),
    .irq_meip(irq_meip), .irq_local(irq_local), .irq_pending(irq_pending),
    .irq_ack(irq_ack), .wfi_wake(wfi_wake), .trap_pc(trap_pc),
    .trap_select(trap_select), .privilege_mode(privilege_mode),
    .mstatus(mstatus), .mie(mie), .mip(mip)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every presented read or redirect consumes one expectation.
  always @(negedge clk) begin
    if (resetn && csr_re) begin
      if (rd_exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: got %h expected no read", rdata);
      end else begin
        check(rd_name_q.pop_front(), rdata, rd_exp_q.pop_front());
      end
    end
    if (resetn && trap_select) begin
      if (trap_exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL trap_unexpected: got trap_pc %h expected no redirect", trap_pc);
      end else begin
        check("trap_pc", trap_pc, trap_exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string nm);
    rd_exp_q.push_back(e);
    rd_name_q.push_back(nm);
    csr_addr = a; csr_re = 1'b1;
    step(1);
    csr_re = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d,
                    input logic exp_fault, input string nm);
    csr_addr = a; csr_op = op; rs1_data = d; uimm = d[4:0]; csr_we = 1'b1;
    #1;
    check({nm, "_fault"}, {31'b0, access_fault}, {31'b0, exp_fault});
    step(1);
    csr_we = 1'b0;
  endtask

  task automatic exc(input logic [31:0] c, input logic [31:0] p, input logic [31:0] b,
                     input logic with_ack, input logic [31:0] exp_pc);
    trap_exp_q.push_back(exp_pc);
    cause = c; pc = p; badaddr = b; exception_event = 1'b1; irq_ack = with_ack;
    step(1);
    exception_event = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic ack(input logic [31:0] p, input logic [31:0] exp_pc);
    trap_exp_q.push_back(exp_pc);
    pc = p; irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
  endtask

  task automatic wait_pending(input string nm);
    int n = 0;
    while (!irq_pending && n < 20) begin
      step(1);
      n++;
    end
    check(nm, {31'b0, irq_pending}, 32'h1);
  endtask

  initial begin
    step(3);
    resetn = 1'b1;
    step(1);
    check("rst_priv", {30'b0, privilege_mode}, 32'h3);
    check("rst_pending", {31'b0, irq_pending}, 32'h0);
    check("rst_trap_sel", {31'b0, trap_select}, 32'h0);
    check("rst_trap_pc", trap_pc, 32'h0);
    rd(12'h300, 32'h0000_1800, "rst_mstatus");
    rd(12'h305, 32'h0000_0200, "rst_mtvec");
    rd(12'h344, 32'h0, "rst_mip");
    rd(12'h301, 32'h4010_1101, "misa");
    rd(12'hF12, 32'h2b, "marchid");
    rd(12'hF14, 32'h0, "mhartid");

    wr(12'h344, OP_RW, 32'hFFFF_FFFF, 1'b0, "mip_wr");
    rd(12'h344, 32'h0, "mip_ro");
    wr(12'h304, OP_RW, 32'hFFFF_FFFF, 1'b0, "mie_all");
    rd(12'h304, 32'h000F_0888, "mie_mask");
    wr(12'h304, OP_RW, 32'h0000_0880, 1'b0, "mie_880");
    wr(12'h300, OP_RS, 32'h8, 1'b0, "mie_set");
    rd(12'h300, 32'h0000_1808, "mstatus_mie");

    // MEI and MTI together: two sync stages, mip register, then request.
    irq_meip = 1'b1; irq_mtip = 1'b1;
    step(3);
    check("pend_early", {31'b0, irq_pending}, 32'h0);
    step(1);
    check("pend_lat", {31'b0, irq_pending}, 32'h1);
    rd(12'h344, 32'h0000_0880, "mip_sampled");
    ack(32'h0000_1000, 32'h0000_0200);
    step(1);
    rd(12'h342, 32'h8000_000B, "mcause_mei");
    rd(12'h341, 32'h0000_1000, "mepc_irq");
    rd(12'h343, 32'h0, "mtval_irq");
    rd(12'h300, 32'h0000_1880, "mstatus_irq");
    check("pend_after_trap", {31'b0, irq_pending}, 32'h0);

    irq_meip = 1'b0;
    wfi = 1'b1;
    step(1);
    wfi = 1'b0;
    step(3);
    check("wfi_wake_on", {31'b0, wfi_wake}, 32'h1);
    check("wfi_no_pend", {31'b0, irq_pending}, 32'h0);
    irq_mtip = 1'b0;
    step(4);
    check("wfi_wake_off", {31'b0, wfi_wake}, 32'h0);

    wr(12'h300, OP_RW, 32'h0002_0000, 1'b0, "mstatus_mprv");
    rd(12'h300, 32'h0002_0000, "mstatus_mpp_u");
    trap_exp_q.push_back(32'h0000_1000);
    mret = 1'b1;
    step(1);
    mret = 1'b0;
    check("mret_priv", {30'b0, privilege_mode}, 32'h0);
    check("mret_mstatus", mstatus, 32'h0000_0080);

    wr(12'h340, OP_RW, 32'h0000_1234, 1'b1, "u_mscratch");
    exc(32'h2, 32'h0000_2000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0200);
    check("exc_priv", {30'b0, privilege_mode}, 32'h3);
    check("exc_mstatus", mstatus, 32'h0);
    rd(12'h340, 32'h0, "mscratch_kept");
    rd(12'h343, 32'h0000_2000, "mtval_pc");
    rd(12'h342, 32'h2, "mcause_exc");
    wr(12'hC00, OP_RW, 32'h5, 1'b1, "cycle_ro");

    repeat (3) begin
      inst_retired = 1'b1;
      step(1);
    end
    inst_retired = 1'b0;
    rd(12'hC02, 32'h3, "instret");
    rd(12'hC82, 32'h0, "instreth");

    // Vectored mode with local line 2 (cause 18).
    wr(12'h305, OP_RW, 32'h0000_0101, 1'b0, "mtvec_vec");
    rd(12'h305, 32'h0000_0101, "mtvec_rb");
    wr(12'h304, OP_RW, 32'h0004_0000, 1'b0, "mie_l2");
    wr(12'h300, OP_RSI, 32'h8, 1'b0, "mie_set2");
    irq_local = 4'b0100;
    wait_pending("pend_local");
    ack(32'h0000_5000, 32'h0000_0148);
    step(1);
    rd(12'h342, 32'h8000_0012, "mcause_l2");
    rd(12'h341, 32'h0000_5000, "mepc_l2");
    irq_local = 4'b0000;
    exc(32'h2, 32'h0000_3000, 32'h0000_0055, 1'b0, 32'h0000_0100);
    rd(12'h343, 32'h0000_0055, "mtval_badaddr");
    rd(12'h300, 32'h0000_1800, "mstatus_exc2");

    // Exception wins over a simultaneous ack; REQ holds one cycle, then drops.
    wr(12'h300, OP_RSI, 32'h8, 1'b0, "mie_set3");
    irq_local = 4'b0100;
    wait_pending("pend_local2");
    exc(32'h5, 32'h0000_4000, 32'h0000_0066, 1'b1, 32'h0000_0100);
    check("stay_req", {31'b0, irq_pending}, 32'h1);
    step(1);
    check("pend_drop", {31'b0, irq_pending}, 32'h0);
    rd(12'h342, 32'h5, "mcause_race");
    rd(12'h343, 32'h0000_0066, "mtval_race");

    wr(12'h300, OP_RSI, 32'h8, 1'b0, "mie_set4");
    wait_pending("pend_local3");
    resetn = 1'b0;
    step(1);
    check("midrst_pend", {31'b0, irq_pending}, 32'h0);
    check("midrst_tsel", {31'b0, trap_select}, 32'h0);
    irq_local = 4'b0000;
    resetn = 1'b1;
    step(1);
    rd(12'h304, 32'h0, "rst2_mie");
    rd(12'h300, 32'h0000_1800, "rst2_mstatus");

    step(2);
    check("rd_q_empty", rd_exp_q.size(), 32'h0);
    check("trap_q_empty", trap_exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
